// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec -- multi-cycle execute unit for a small accumulator-style datapath.
//
// Accepts one operation at a time. An operation runs through a short FSM:
//   IDLE -> FETCH -> CALC -> DONE -> IDLE        (LOAD/ADD/ADDI/SUB/SUBI/
//                                                  CLEAR/DISPLAY)
//   IDLE -> FETCH -> MULT (16 cycles) -> DONE -> IDLE   (MUL)
// FETCH waits one cycle for the registered memory read. At the end of FETCH
// the memory operands are captured. MUL is a serial shift-add that handles
// one multiplier bit per cycle.
//
// Parameters
//   IMM_W            width of the two's-complement immediate (must be < 16)
//
// Ports
//   clk              single clock, rising edge
//   rst              synchronous active-high reset
//   opPronta         start request, sampled only in IDLE
//   opcode[2:0]      LOAD=000 ADD=001 ADDI=010 SUB=011 SUBI=100 MUL=101
//                    CLEAR=110 DISPLAY=111
//   imm[IMM_W-1:0]   immediate operand, sign-extended to 16 bits
//   v1RAM, v2RAM     16-bit operands read from memory
//   valorGuardarRAM  result word. It holds its value from one DONE to the next.
//   escrever         write-back enable, one-cycle pulse in DONE
//   pronto           completion pulse, high for the DONE cycle
//   ocupado          busy, high in every state except IDLE
//   overflow         signed overflow of ADD/ADDI/SUB/SUBI. It holds its value
//                    from one DONE to the next.
// ---------------------------------------------------------------------------
module alu_exec #(
  parameter int IMM_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             opPronta,
  input  logic [2:0]       opcode,
  input  logic [IMM_W-1:0] imm,
  input  logic [15:0]      v1RAM,
  input  logic [15:0]      v2RAM,
  output logic [15:0]      valorGuardarRAM,
  output logic             escrever,
  output logic             pronto,
  output logic             ocupado,
  output logic             overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_MULT,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  state_t      state;
  logic [2:0]  op_r;      // opcode latched at acceptance
  logic [15:0] imm_r;     // sign-extended immediate latched at acceptance
  logic [15:0] a_r;       // operand A (v1RAM)
  logic [15:0] b_r;       // operand B (v2RAM)
  logic [15:0] acc_r;     // shift-add partial product
  logic [3:0]  cnt_r;     // multiplier bit index while in MULT

  logic [15:0] imm_ext;
  logic [15:0] calc_res;
  logic        calc_ovf;
  logic        calc_wr;
  logic [15:0] mul_next;

  // -------------------------------------------------------------------------
  // Combinational datapath
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first. A path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    imm_ext  = {{(16-IMM_W){imm[IMM_W-1]}}, imm};
    calc_res = 16'h0000;
    calc_ovf = 1'b0;
    calc_wr  = 1'b1;

    unique case (op_r)
      OP_LOAD: calc_res = imm_r;
      OP_ADD: begin
        calc_res = a_r + b_r;
        // Addition overflows when both operands have the same sign and the
        // result has a different sign.
        calc_ovf = (a_r[15] == b_r[15]) && (calc_res[15] != a_r[15]);
      end
      OP_ADDI: begin
        calc_res = a_r + imm_r;
        calc_ovf = (a_r[15] == imm_r[15]) && (calc_res[15] != a_r[15]);
      end
      OP_SUB: begin
        calc_res = a_r - b_r;
        // Subtraction overflows when the operands have different signs and
        // the result sign differs from the minuend.
        calc_ovf = (a_r[15] != b_r[15]) && (calc_res[15] != a_r[15]);
      end
      OP_SUBI: begin
        calc_res = a_r - imm_r;
        calc_ovf = (a_r[15] != imm_r[15]) && (calc_res[15] != a_r[15]);
      end
      OP_CLEAR: begin
        calc_res = 16'h0000;
        calc_wr  = 1'b0;
      end
      OP_DISPLAY: begin
        calc_res = a_r;
        calc_wr  = 1'b0;
      end
      default: calc_res = 16'h0000;  // OP_MUL never reaches CALC
    endcase

    // One shift-add step. Bit cnt_r of the multiplier adds A << cnt_r to the
    // partial product. Bits shifted past bit 15 are dropped, which gives the
    // product modulo 2^16.
    mul_next = acc_r + (imm_r[cnt_r] ? (a_r << cnt_r) : 16'h0000);
  end

  // -------------------------------------------------------------------------
  // FSM and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: state is assigned non-blocking only. All registers then update
  // together on the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      op_r            <= 3'b000;
      imm_r           <= 16'h0000;
      a_r             <= 16'h0000;
      b_r             <= 16'h0000;
      acc_r           <= 16'h0000;
      cnt_r           <= 4'd0;
      valorGuardarRAM <= 16'h0000;
      escrever        <= 1'b0;
      pronto          <= 1'b0;
      ocupado         <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      // Pulses are low unless the transition into DONE raises them.
      pronto   <= 1'b0;
      escrever <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (opPronta) begin
            op_r    <= opcode;
            imm_r   <= imm_ext;
            ocupado <= 1'b1;
            state   <= S_FETCH;
          end
        end

        S_FETCH: begin
          // The memory read data becomes valid during this cycle.
          a_r   <= v1RAM;
          b_r   <= v2RAM;
          acc_r <= 16'h0000;
          cnt_r <= 4'd0;
          state <= (op_r == OP_MUL) ? S_MULT : S_CALC;
        end

        S_CALC: begin
          valorGuardarRAM <= calc_res;
          overflow        <= calc_ovf;
          escrever        <= calc_wr;
          pronto          <= 1'b1;
          state           <= S_DONE;
        end

        S_MULT: begin
          acc_r <= mul_next;
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            valorGuardarRAM <= mul_next;
            overflow        <= 1'b0;
            escrever        <= 1'b1;
            pronto          <= 1'b1;
            state           <= S_DONE;
          end
        end

        S_DONE: begin
          ocupado <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          ocupado <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter IMM_W, default 7, giving the width of the two's-complement immediate field.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port opPronta, input, 1, the start request; it is sampled only in IDLE.
REQ-005 The block SHALL have port opcode, input, 3, the operation: LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101, CLEAR=110, DISPLAY=111.
REQ-006 The block SHALL have port imm, input, IMM_W, the immediate operand, sign-extended to 16 bits.
REQ-007 The block SHALL have ports v1RAM and v2RAM, input, 16 each, the operands read from memory.
REQ-008 The block SHALL have port valorGuardarRAM, output, 16, the result word written back to memory.
REQ-009 The block SHALL have ports escrever (write-back enable), pronto (completion pulse), ocupado (busy) and overflow, all output, 1 each.

Function
REQ-010 The FSM SHALL have states IDLE, FETCH, CALC, MULT and DONE.
REQ-011 In IDLE with opPronta=1, the block SHALL latch opcode and sign-extended imm into internal registers and enter FETCH.
REQ-012 opPronta outside IDLE SHALL be ignored (no queuing); input changes after latching SHALL NOT affect the operation in flight.
REQ-013 FETCH SHALL last exactly one cycle to cover the registered memory read; at its end v1RAM and v2RAM SHALL be captured into operand registers A and B.
REQ-014 From FETCH the next state SHALL be MULT for MUL and CALC for all other opcodes.
REQ-015 CALC SHALL last one cycle and compute R: LOAD R=imm; ADD R=A+B; ADDI R=A+imm; SUB R=A-B; SUBI R=A-imm; CLEAR R=0; DISPLAY R=A.
REQ-016 MUL SHALL compute R=A*imm (low 16 bits) by iterative shift-add over all 16 multiplier bits, one bit per cycle; MULT SHALL last exactly 16 cycles, counted by a 4-bit counter cleared on entry.
REQ-017 All arithmetic SHALL be two's complement modulo 2^16, with no saturation.
REQ-018 overflow SHALL be set at DONE only for ADD/ADDI/SUB/SUBI with signed overflow (operand signs meeting the add/subtract rule, result sign differing); it SHALL be 0 for all other opcodes.
REQ-019 DONE SHALL last one cycle, with pronto=1, valorGuardarRAM=R, and escrever=1 for LOAD/ADD/ADDI/SUB/SUBI/MUL or escrever=0 for CLEAR/DISPLAY; the next state SHALL be IDLE.
REQ-020 valorGuardarRAM and overflow SHALL hold their DONE values until the next DONE or reset.
REQ-021 ocupado SHALL be 1 in every state except IDLE.
REQ-022 Latency from the edge sampling opPronta to pronto high SHALL be 3 cycles for non-MUL opcodes and 18 cycles for MUL.
REQ-023 A new opPronta SHALL be accepted no earlier than the cycle after DONE, giving back-to-back throughput of one operation per 4 cycles (non-MUL).

Reset
REQ-024 rst=1 SHALL force IDLE and clear valorGuardarRAM, escrever, pronto, ocupado, overflow, A, B, the counter and the latched opcode/imm to 0.
REQ-025 rst SHALL take priority over opPronta and SHALL abort any operation in flight, including mid-MULT, with no pronto or escrever pulse.
REQ-026 After rst deasserts, the block SHALL accept opPronta on the first edge where rst=0.

Verification
REQ-027 ADD: v1RAM=0x0005, v2RAM=0x0007, one-cycle opPronta -> pronto, escrever=1 and valorGuardarRAM=0x000C exactly 3 cycles later, overflow=0.
REQ-028 SUBI: imm=7'h7F (-1), v1RAM=0x8000 -> R=0x8001, overflow=0; ADD 0x7FFF+0x0001 -> R=0x8000, overflow=1.
REQ-029 MUL: v1RAM=0x0003, imm=7'h7E (-2) -> R=0xFFFA at pronto 18 cycles after start; ocupado=1 throughout.
REQ-030 CLEAR and DISPLAY (v1RAM=0x1234) -> pronto with escrever=0; R=0x0000 and R=0x1234 respectively.
REQ-031 rst asserted on the 8th MULT cycle -> same edge: ocupado=0, outputs 0, no pronto; a following LOAD imm=7'h05 -> R=0x0005 3 cycles after start.
REQ-032 opPronta held high continuously with ADD -> exactly one pronto every 4 cycles; opcode changes while ocupado=1 do not alter R.
